// File: rtl/led_counter.sv
// Programmable LED counter: prescaled up/down count with modulo, load, and free-run or one-shot modes.
// Latency: count/tc/done update on the tick edge; load reaches count in 1 edge; LED is a slice of count.
// Backpressure: none; enable=0 freezes prescaler and count, done=1 suppresses ticks until load or reset.
module led_counter #(
    parameter int WIDTH      = 32,
    parameter int PRESCALE_W = 8,
    parameter int LED_W      = 4,
    parameter int LED_LSB    = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  up_down,
    input  logic                  mode,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [WIDTH-1:0]      modulo,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_value,
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic                  done,
    output logic [LED_W-1:0]      LED
);

    // Reject geometries where the LED window falls outside the counter.
    if ((WIDTH < 2) || (LED_LSB + LED_W > WIDTH)) begin : g_bad_params
        $error("led_counter: need WIDTH >= 2 and LED_LSB + LED_W <= WIDTH");
    end

    localparam logic [WIDTH-1:0]      CNT_ONE = WIDTH'(1);
    localparam logic [PRESCALE_W-1:0] PRE_ONE = PRESCALE_W'(1);

    logic [PRESCALE_W-1:0] pre_cnt;
    logic                  active;
    logic                  pre_hit;
    logic                  tick;
    logic [WIDTH-1:0]      cnt_step;
    logic [WIDTH-1:0]      terminal;
    logic                  hit;

    // Prescaler only advances while enabled and not parked in one-shot completion.
    assign active  = enable & ~done;
    assign pre_hit = (pre_cnt == prescale);
    assign tick    = active & pre_hit;

    // Candidate next count and the terminal value for the current direction.
    // Counting up, anything at or above modulo wraps to 0; counting down, 0 reloads modulo
    // and values above modulo simply decrement.
    always_comb begin
        cnt_step = count;
        terminal = '0;
        if (up_down) begin
            terminal = modulo;
            cnt_step = (count >= modulo) ? '0 : count + CNT_ONE;
        end else begin
            terminal = '0;
            cnt_step = (count == '0) ? modulo : count - CNT_ONE;
        end
    end

    assign hit = (cnt_step == terminal);

    // Counter, prescaler and flags: load beats tick beats hold; tc is a single-edge pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            pre_cnt <= '0;
            tc      <= 1'b0;
            done    <= 1'b0;
        end else if (load) begin
            count   <= load_value;
            pre_cnt <= '0;
            tc      <= 1'b0;
            done    <= 1'b0;
        end else begin
            tc <= tick & hit;
            if (active) begin
                pre_cnt <= pre_hit ? '0 : pre_cnt + PRE_ONE;
            end
            if (tick) begin
                count <= cnt_step;
                if (mode && hit) begin
                    done <= 1'b1;
                end
            end
        end
    end

    assign LED = count[LED_LSB +: LED_W];

endmodule

// File: tb/tb_led_counter.sv
// Bench for led_counter: vector table plus hand sequences; expected outputs are queued when
// inputs are driven and popped/compared one edge later.
module tb_led_counter;

    localparam int WIDTH      = 32;
    localparam int PRESCALE_W = 8;
    localparam int LED_W      = 4;
    localparam int LED_LSB    = 24;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  enable;
    logic                  up_down;
    logic                  mode;
    logic [PRESCALE_W-1:0] prescale;
    logic [WIDTH-1:0]      modulo;
    logic                  load;
    logic [WIDTH-1:0]      load_value;
    logic [WIDTH-1:0]      count;
    logic                  tc;
    logic                  done;
    logic [LED_W-1:0]      led;

    always #5 clk = ~clk;

    led_counter #(
        .WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W), .LED_W(LED_W), .LED_LSB(LED_LSB)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .mode(mode),
        .prescale(prescale), .modulo(modulo), .load(load), .load_value(load_value),
        .count(count), .tc(tc), .done(done), .LED(led)
    );

    typedef struct {
        logic [WIDTH-1:0] count;
        logic             tc;
        logic             done;
        string            name;
    } exp_t;

    typedef struct {
        logic                  en;
        logic                  ud;
        logic                  md;
        logic                  ld;
        logic [PRESCALE_W-1:0] ps;
        logic [WIDTH-1:0]      mo;
        logic [WIDTH-1:0]      lv;
        logic [WIDTH-1:0]      e_count;
        logic                  e_tc;
        logic                  e_done;
        string                 name;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic cmp(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_exp(input exp_t e);
        logic [WIDTH-1:0] c;
        c = e.count;
        cmp({e.name, " count"}, count, c);
        cmp({e.name, " tc"},    WIDTH'(tc),   WIDTH'(e.tc));
        cmp({e.name, " done"},  WIDTH'(done), WIDTH'(e.done));
        cmp({e.name, " LED"},   WIDTH'(led),  WIDTH'(c[LED_LSB +: LED_W]));
    endtask

    task automatic drive(input logic en, input logic ud, input logic md, input logic ld,
                         input logic [PRESCALE_W-1:0] ps, input logic [WIDTH-1:0] mo,
                         input logic [WIDTH-1:0] lv);
        enable = en; up_down = ud; mode = md; load = ld;
        prescale = ps; modulo = mo; load_value = lv;
    endtask

    // Drive one cycle of stimulus, queue its expectation, then check after the edge.
    task automatic apply(input logic en, input logic ud, input logic md, input logic ld,
                         input logic [PRESCALE_W-1:0] ps, input logic [WIDTH-1:0] mo,
                         input logic [WIDTH-1:0] lv, input logic [WIDTH-1:0] e_count,
                         input logic e_tc, input logic e_done, input string name);
        exp_t e;
        drive(en, ud, md, ld, ps, mo, lv);
        e.count = e_count; e.tc = e_tc; e.done = e_done; e.name = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard underflow at %s", name);
        end else begin
            check_exp(sb.pop_front());
        end
    endtask

    task automatic add_vec(input logic en, input logic ud, input logic md, input logic ld,
                           input logic [PRESCALE_W-1:0] ps, input logic [WIDTH-1:0] mo,
                           input logic [WIDTH-1:0] lv, input logic [WIDTH-1:0] e_count,
                           input logic e_tc, input logic e_done, input string name);
        vec_t v;
        v.en = en; v.ud = ud; v.md = md; v.ld = ld; v.ps = ps; v.mo = mo; v.lv = lv;
        v.e_count = e_count; v.e_tc = e_tc; v.e_done = e_done; v.name = name;
        vecs.push_back(v);
    endtask

    // Assert reset mid-cycle and confirm outputs clear before the next edge.
    task automatic async_reset_check(input string name);
        #3;
        reset = 1'b1;
        #1;
        cmp({name, " count"}, count, '0);
        cmp({name, " tc"},    WIDTH'(tc),   '0);
        cmp({name, " done"},  WIDTH'(done), '0);
        cmp({name, " LED"},   WIDTH'(led),  '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        // Free-run up, prescale 0, modulo 9: count k%10 after k edges, tc when count is 9.
        for (int i = 1; i <= 25; i++) begin
            add_vec(1, 1, 0, 0, 0, 9, 0, WIDTH'(i % 10), (i % 10) == 9, 0, "freerun");
        end
        // One-shot down from 5 to 0, then parked at 0, then reload restarts.
        add_vec(1, 0, 1, 1, 0, 5, 5, 5, 0, 0, "oneshot load");
        for (int k = 4; k >= 0; k--) begin
            add_vec(1, 0, 1, 0, 0, 5, 0, WIDTH'(k), k == 0, k == 0, "oneshot down");
        end
        for (int i = 0; i < 20; i++) begin
            add_vec(1, 0, 1, 0, 0, 5, 0, 0, 0, 1, "oneshot hold");
        end
        add_vec(1, 0, 1, 1, 0, 5, 5, 5, 0, 0, "oneshot reload");
        add_vec(1, 0, 1, 0, 0, 5, 0, 4, 0, 0, "oneshot restart");

        // Reset held 5 cycles, then 20 idle cycles with enable low.
        reset = 1'b1;
        drive(0, 1, 0, 0, 0, 9, 0);
        #1;
        cmp("reset initial count", count, '0);
        for (int i = 0; i < 5; i++) apply(0, 1, 0, 0, 0, 9, 0, 0, 0, 0, "in reset");
        reset = 1'b0;
        for (int i = 0; i < 20; i++) apply(0, 1, 0, 0, 0, 9, 0, 0, 0, 0, "idle");

        foreach (vecs[i]) begin
            apply(vecs[i].en, vecs[i].ud, vecs[i].md, vecs[i].ld, vecs[i].ps, vecs[i].mo,
                  vecs[i].lv, vecs[i].e_count, vecs[i].e_tc, vecs[i].e_done, vecs[i].name);
        end

        // Prescaler 3: a tick every 4 enabled edges.
        apply(1, 1, 0, 1, 3, 255, 0, 0, 0, 0, "presc load");
        for (int k = 1; k <= 40; k++) begin
            apply(1, 1, 0, 0, 3, 255, 0, WIDTH'(k / 4), 0, 0, "presc run");
        end
        apply(1, 1, 0, 0, 3, 255, 0, 10, 0, 0, "presc mid1");
        apply(1, 1, 0, 0, 3, 255, 0, 10, 0, 0, "presc mid2");
        for (int i = 0; i < 7; i++) apply(0, 1, 0, 0, 3, 255, 0, 10, 0, 0, "presc frozen");
        apply(1, 1, 0, 0, 3, 255, 0, 10, 0, 0, "presc resume1");
        apply(1, 1, 0, 0, 3, 255, 0, 11, 0, 0, "presc resume2");

        // Load wins over a tick that would have reached terminal.
        apply(1, 1, 0, 1, 0, 9, 8, 8, 0, 0, "load 8");
        apply(1, 1, 0, 1, 0, 9, 3, 3, 0, 0, "load over tick");
        apply(1, 1, 0, 0, 0, 9, 0, 4, 0, 0, "after load tick");

        // Loaded value above modulo: up wraps to 0 without tc, down just decrements.
        apply(1, 1, 0, 1, 0, 10, 50, 50, 0, 0, "load 50 up");
        apply(1, 1, 0, 0, 0, 10, 0, 0, 0, 0, "over mod wrap");
        apply(1, 1, 0, 0, 0, 10, 0, 1, 0, 0, "over mod next");
        apply(1, 0, 0, 1, 0, 10, 50, 50, 0, 0, "load 50 down");
        apply(1, 0, 0, 0, 0, 10, 0, 49, 0, 0, "over mod dec");

        // Modulo 0 with prescale 0: every tick reaches terminal.
        apply(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, "mod0 load");
        for (int i = 0; i < 3; i++) apply(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, "mod0 tc");

        // LED window carries count[27:24].
        apply(0, 1, 0, 1, 0, 32'hFFFF_FFFF, 32'h0AFF_FFFF, 32'h0AFF_FFFF, 0, 0, "led load");
        apply(1, 1, 0, 0, 0, 32'hFFFF_FFFF, 0, 32'h0B00_0000, 0, 0, "led tick");
        apply(1, 1, 0, 0, 0, 32'hFFFF_FFFF, 0, 32'h0B00_0001, 0, 0, "led tick2");
        async_reset_check("async rst count");

        // After reset, counting down from 0 reloads modulo.
        apply(1, 0, 0, 0, 0, 5, 0, 5, 0, 0, "post reset");

        // Reset also clears a completed one-shot.
        apply(1, 0, 1, 1, 0, 5, 1, 1, 0, 0, "os2 load");
        apply(1, 0, 1, 0, 0, 5, 0, 0, 1, 1, "os2 done");
        async_reset_check("async rst done");
        apply(1, 0, 1, 0, 0, 5, 0, 5, 0, 0, "os2 after reset");

        cmp("scoreboard drained", WIDTH'(sb.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_counter.md
# led_counter

Parametrised, programmable successor to the board LED counter: a WIDTH-bit counter with a runtime prescaler, up/down direction, programmable modulo, synchronous load, and a free-running or one-shot mode. It sits between the board clock/reset and the LED pins. It drives an LED_W-bit window of the count and flags terminal-count events so other logic (timers, blinkers) can reuse it.

## Interface
Parameters:
- WIDTH, 32, counter width (≥ 2)
- PRESCALE_W, 8, prescaler width
- LED_W, 4, LED output width
- LED_LSB, 24, lowest count bit driven to LED; LED_LSB + LED_W ≤ WIDTH (elaboration error otherwise)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- enable  in  1  count enable; gates prescaler and count
- up_down  in  1  1 = count up, 0 = count down
- mode  in  1  0 = free-running (wrap), 1 = one-shot (stop at terminal)
- prescale  in  PRESCALE_W  tick every prescale+1 enabled cycles
- modulo  in  WIDTH  count range is 0..modulo
- load  in  1  synchronous load strobe
- load_value  in  WIDTH  value loaded on load
- count  out  WIDTH  current count (registered)
- tc  out  1  one-cycle terminal-count pulse (registered)
- done  out  1  sticky one-shot completion flag (registered)
- LED  out  LED_W  count[LED_LSB +: LED_W]

## Operation
- Reset (async assert): count, internal pre_cnt, tc, done all 0; LED = 0.
- Priority per edge: load > tick > hold.
- Load, independent of enable: count ← load_value, pre_cnt ← 0, done ← 0, tc ← 0.
- Prescaler, when enable=1 and done=0:
  - if pre_cnt == prescale: tick, and pre_cnt ← 0
  - otherwise pre_cnt ← pre_cnt+1
  - pre_cnt holds when enable=0 or done=1.
- Tick, counting up:
  - next = (count ≥ modulo) ? 0 : count+1
  - terminal = modulo
  - a loaded count > modulo wraps to 0 on the next tick.
- Tick, counting down:
  - next = (count == 0) ? modulo : count−1
  - terminal = 0
  - a count > modulo simply decrements.
- tc ← 1 on a tick whose next == terminal; 0 on every other edge. It is never high for two consecutive cycles unless successive ticks each reach terminal (prescale=0 and modulo=0).
- One-shot (mode=1):
  - on a tick reaching terminal, count ← terminal, tc ← 1, done ← 1.
  - while done=1, ticks are suppressed and count holds.
  - only load or reset clears done.
- Free-running (mode=0): done stays 0.
- up_down, mode, modulo and prescale are sampled every edge, with no shadowing. A prescale change below the current pre_cnt takes effect after pre_cnt wraps at its maximum; benches must not rely on this case.
- LED is a pure slice of the count register, with no extra logic.

## Timing
- Latency: count, tc and done update on the same rising edge as the tick; tc is high in the cycle count shows terminal.
- The first tick comes at the (prescale+1)-th rising edge sampled with enable=1 after reset release or load.
- Load to count: 1 edge.
- Reset mid-operation clears all state immediately (asynchronous). Deassertion is assumed synchronised upstream.
- enable dropped mid-prescale: pre_cnt and count freeze; counting resumes from the same pre_cnt.
- Simultaneous load and tick: load wins, tc = 0.

## Test plan
- Reset/idle: hold reset for 5 cycles, then release with enable=0 for 20 cycles → count=0, tc=0, done=0, LED=0 throughout. Assert reset asynchronously mid-count → outputs go to 0 before the next edge.
- Free-run up: prescale=0, modulo=9, mode=0, enable=1 → count 0,1,…,9,0,…; tc=1 only when count=9, exactly once per 10 cycles; done=0.
- Prescaler/enable: prescale=3, modulo=255, up.
  - After 40 enabled cycles → count=10.
  - Drop enable for 7 cycles after the 2nd cycle of a prescale period → count and pre_cnt hold.
  - After enable returns, the next tick comes 2 cycles later.
- One-shot down:
  - load_value=5, modulo=5, up_down=0, mode=1 → count 5,4,3,2,1,0; tc=1 and done=1 with count=0.
  - count stays 0 for 20 more enabled cycles.
  - load 5 → done=0 and counting restarts.
- Load edge cases:
  - load concurrent with a tick → count=load_value, tc=0.
  - up mode, modulo=10, load 50 → next tick gives count=0 with tc=0.
- LED slice (WIDTH=32, LED_LSB=24):
  - load 0x0AFFFFFF, modulo=0xFFFFFFFF, up → LED=0xA.
  - one tick → count=0x0B000000, LED=0xB.
